// File: rtl/mem_responder.sv
// Single-port word memory answering one load/store at a time over req/ready,
// with WAIT_CYCLES wait states between acceptance and the response pulse.
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  accept, enter_resp;

  logic                  we_p0, mis_p0;
  logic [DEPTH_LOG2-1:0] idx_p0;
  logic [31:0]           wdata_p0;

  logic                  acc_we, acc_mis;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [31:0]           acc_wdata;

  logic                  err_p1;
  logic [31:0]           mem [DEPTH];

  logic                  unused_addr;
  assign unused_addr = ^{addr[31:DEPTH_LOG2+2]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              cnt <= '0;
    else if (accept)         cnt <= CNT_LOAD;
    else if (state == WAIT)  cnt <= cnt - 1'b1;
  end

  // Request capture stage: later changes on addr/wdata are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= we;
      idx_p0   <= addr[DEPTH_LOG2+1:2];
      wdata_p0 <= wdata;
      mis_p0   <= (addr[1:0] != 2'b00);
    end
  end

  // With zero wait states RESP is entered on the accepting edge, so use the live request
  always_comb begin
    acc_we    = we_p0;
    acc_idx   = idx_p0;
    acc_wdata = wdata_p0;
    acc_mis   = mis_p0;
    if (state == IDLE) begin
      acc_we    = we;
      acc_idx   = addr[DEPTH_LOG2+1:2];
      acc_wdata = wdata;
      acc_mis   = (addr[1:0] != 2'b00);
    end
  end

  // Response stage: commit store or fetch load on the edge entering RESP
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_we) mem[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata  <= 32'h0;
      err_p1 <= 1'b0;
    end else if (enter_resp) begin
      err_p1 <= acc_mis;
      if (!acc_we) rdata <= mem[acc_idx];
    end
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);
  assign err   = ready & err_p1;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a default build and a zero-wait build
// compared against an array-based memory model with expected latencies.
module tb_mem_responder;

  localparam int WA = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_a = 1'b0, we_a = 1'b0;
  logic [31:0] addr_a = '0, wdata_a = '0;
  logic [31:0] rdata_a;
  logic        ready_a, err_a, busy_a;

  logic        req_b = 1'b0, we_b = 1'b0;
  logic [31:0] addr_b = '0, wdata_b = '0;
  logic [31:0] rdata_b;
  logic        ready_b, err_b, busy_b;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] model_mem [2][256];
  bit          model_vld [2][256];
  logic [31:0] model_rd  [2];
  bit          rd_known  [2];
  int          lat_exp   [2];

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .err(err_a), .busy(busy_a)
  );

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .err(err_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int b, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (b == 0) begin req_a = r; we_a = w; addr_a = a; wdata_a = d; end
    else        begin req_b = r; we_b = w; addr_b = a; wdata_b = d; end
  endtask

  task automatic sample(input int b, output logic [31:0] rd, output logic rdy,
                        output logic e, output logic bsy);
    if (b == 0) begin rd = rdata_a; rdy = ready_a; e = err_a; bsy = busy_a; end
    else        begin rd = rdata_b; rdy = ready_b; e = err_b; bsy = busy_b; end
  endtask

  task automatic access(input int b, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd_o, output logic e_o);
    int          idx, lat;
    logic [31:0] rd, junk;
    logic        rdy, e, bsy;
    idx = int'(a[9:2]);
    rdy = 1'b0; lat = 0; rd = '0; e = 1'b0; bsy = 1'b0;
    @(negedge clk);
    drive(b, 1'b1, w, a, d);
    while (!rdy && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      sample(b, rd, rdy, e, bsy);
      if (!rdy) begin
        chk("busy_wait", {31'b0, bsy}, 32'd1);
        junk = $urandom;
        drive(b, 1'b1, w, junk, ~junk);
      end
    end
    chk("latency", 32'(lat), 32'(lat_exp[b]));
    drive(b, 1'b0, 1'b0, 32'h0, 32'h0);
    if (rdy) begin
      chk("busy_resp", {31'b0, bsy}, 32'd1);
      chk("err", {31'b0, e}, {31'b0, (a[1:0] != 2'b00)});
      if (w) begin
        model_mem[b][idx] = d;
        model_vld[b][idx] = 1'b1;
      end else begin
        rd_known[b] = model_vld[b][idx];
        model_rd[b] = model_mem[b][idx];
      end
      if (rd_known[b]) chk(w ? "rdata_hold" : "rdata_load", rd, model_rd[b]);
    end
    rd_o = rd;
    e_o  = e;
    @(posedge clk); #1;
    sample(b, junk, rdy, e, bsy);
    chk("idle_ready", {31'b0, rdy}, 32'd0);
    chk("idle_busy", {31'b0, bsy}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, tmp;
    logic        e, rdy, bsy;
    logic [7:0]  ridx;
    int          b, n;
    logic        w;

    lat_exp[0] = WA + 1;
    lat_exp[1] = 1;
    for (int i = 0; i < 2; i++) begin
      model_rd[i] = 32'h0;
      rd_known[i] = 1'b1;
      for (int j = 0; j < 256; j++) begin
        model_vld[i][j] = 1'b0;
        model_mem[i][j] = 32'h0;
      end
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      sample(i, rd, rdy, e, bsy);
      chk("rst_ready", {31'b0, rdy}, 32'd0);
      chk("rst_busy", {31'b0, bsy}, 32'd0);
      chk("rst_err", {31'b0, e}, 32'd0);
      chk("rst_rdata", rd, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_no_ready_a", {31'b0, ready_a}, 32'd0);
      chk("idle_no_ready_b", {31'b0, ready_b}, 32'd0);
    end

    // Store then load
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, e);
    chk("st_err", {31'b0, e}, 32'd0);
    access(0, 1'b0, 32'h10, 32'h0, rd, e);
    chk("ld_value", rd, 32'hDEADBEEF);

    // Misaligned store and alias loads
    access(0, 1'b1, 32'h13, 32'h12345678, rd, e);
    chk("mis_err", {31'b0, e}, 32'd1);
    access(0, 1'b0, 32'h10, 32'h0, rd, e);
    chk("mis_ld", rd, 32'h12345678);
    chk("mis_ld_err", {31'b0, e}, 32'd0);
    access(0, 1'b0, 32'h410, 32'h0, rd, e);
    chk("alias_ld", rd, 32'h12345678);

    // Back-to-back loads with req held
    access(0, 1'b1, 32'h0, 32'h00000001, rd, e);
    n = 3 * (WA + 2);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i <= n; i++) begin
      int p;
      @(posedge clk); #1;
      p = (i - 1) % (WA + 2);
      sample(0, rd, rdy, e, bsy);
      chk("b2b_ready", {31'b0, rdy}, {31'b0, (p == WA)});
      chk("b2b_busy", {31'b0, bsy}, {31'b0, (p != WA + 1)});
      if (p == WA) chk("b2b_rdata", rd, 32'h00000001);
      if (i == n - 1) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    model_rd[0] = 32'h00000001;
    rd_known[0] = 1'b1;

    // Reset during a pending store
    access(0, 1'b1, 32'h20, 32'h11111111, rd, e);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'hAAAA5555);
    @(posedge clk); #2;
    chk("pend_busy", {31'b0, busy_a}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_ready", {31'b0, ready_a}, 32'd0);
    chk("arst_busy", {31'b0, busy_a}, 32'd0);
    chk("arst_err", {31'b0, err_a}, 32'd0);
    chk("arst_rdata", rdata_a, 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    model_rd[0] = 32'h0;
    model_rd[1] = 32'h0;
    rd_known[0] = 1'b1;
    rd_known[1] = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    access(0, 1'b0, 32'h20, 32'h0, rd, e);
    chk("arst_mem_kept", rd, 32'h11111111);

    // Zero-wait build
    access(1, 1'b1, 32'h4, 32'hCAFEF00D, rd, e);
    access(1, 1'b0, 32'h4, 32'h0, rd, e);
    chk("w0_ld", rd, 32'hCAFEF00D);

    // Random mix on both builds
    for (int i = 0; i < 80; i++) begin
      b    = int'($urandom_range(0, 1));
      ridx = 8'($urandom_range(0, 15));
      w    = 1'($urandom_range(0, 1));
      if (!w && !model_vld[b][ridx]) w = 1'b1;
      tmp  = $urandom;
      access(b, w, {tmp[31:10], ridx, tmp[1:0]}, $urandom, rd, e);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
